// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Definitions shared by the SPI master (transmitter_SPI) and slave
// (receiver_spi):
//   - SPI_DEFAULT_WIDTH : default word length in bits
//   - MODE0..MODE3      : SPI mode encodings, packed as {CKP, CPH}
//   - spi_state_t       : frame FSM states (IDLE, ACTIVE)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package spi_pkg;

  localparam int SPI_DEFAULT_WIDTH = 8;

  // {CKP, CPH}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings an asynchronous pin into the clk domain through STAGES flops and
// produces single-cycle registered rise/fall pulses from the synchronised
// level.
//
// Parameters:
//   STAGES    : number of synchroniser flops (>= 2)
//   RESET_VAL : level the synchroniser assumes while in reset (the pin's
//               idle level, so no spurious edge follows reset release)
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   i_pin  in  asynchronous input pin
//   o_rise out one-cycle pulse after a synchronised 0->1 transition
//   o_fall out one-cycle pulse after a synchronised 1->0 transition
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; with = the synchroniser chain
  // would collapse into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule : spi_sync_edge

// File: rtl/receiver_spi.sv
// -----------------------------------------------------------------------------
// receiver_spi
// SPI slave receiver, oversampled by clk (no logic runs on SCK). Deserialises
// MOSI (MSB first) into WIDTH-bit words delivered on a valid/ack handshake and
// simultaneously returns a local word on MISO (MSB first). Several words may
// be sent back-to-back inside one CS frame.
//
// Parameters:
//   WIDTH       : bits per word (4..16)
//   SYNC_STAGES : synchroniser flops on SCK/CS/MOSI (>= 2)
// Ports:
//   clk      in   system clock (>= 8x SCK)
//   rst      in   asynchronous active-low reset
//   CKP/CPH  in   SPI clock polarity / phase, latched at CS fall
//   SCK/CS   in   serial clock / active-low chip select from master
//   MOSI     in   serial data from master
//   MISO     out  serial data to master
//   tx_data  in   word returned on MISO in the next word slot
//   rx_data  out  last complete received word
//   rx_valid out  rx_data holds an unacknowledged word
//   rx_ack   in   consumer accepts rx_data
//   busy     out  synchronised CS is low (frame in progress)
// Build option:
//   SPI_RX_OVERRUN_EN : adds output rx_overrun, set when a word completes
//                       while a previous one is still unacknowledged, cleared
//                       by rx_ack.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module receiver_spi
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
`ifdef SPI_RX_OVERRUN_EN
  output logic             rx_overrun,
`endif
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  // Pin conditioning
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst),
    .i_pin  (SCK),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  // CS idles high, so its synchroniser resets high.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst),
    .i_pin  (CS),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // MOSI only needs a level: it is stable for half an SCK period around the
  // sample edge, so the one-cycle skew against the SCK pulses is harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mosi_sync <= '0;
    else      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // Frame state
  spi_state_t        r_state;
  spi_state_t        w_next_state;
  logic              r_ckp;
  logic              r_cph;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_rx_shift;
  logic [WIDTH-1:0]  r_tx_shift;
  logic              r_hold;
  logic              r_miso;
  logic [WIDTH-1:0]  r_rx_data;
  logic              r_rx_valid;

  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_shift;
  logic w_done;

  // Edge roles derived from the mode latched for this frame.
  always_comb begin
    w_lead   = r_ckp ? w_sck_fall : w_sck_rise;
    w_trail  = r_ckp ? w_sck_rise : w_sck_fall;
    w_sample = r_cph ? w_trail : w_lead;
    w_shift  = r_cph ? w_lead  : w_trail;
    w_done   = (r_state == ACTIVE) && (r_cnt == CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: the next state is defaulted before the case so that every path
  // assigns it; a missing assignment here would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_next_state = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Shift registers, bit counter and MISO.
  // r_hold marks that the next shift edge must present the freshly loaded MSB
  // instead of shifting: the first leading edge with CPH=1, and the trailing
  // edge that follows a word's last sample with CPH=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ckp      <= 1'b0;
      r_cph      <= 1'b0;
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_hold     <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          r_cnt  <= '0;
          if (w_cs_fall) begin
            r_ckp      <= CKP;
            r_cph      <= CPH;
            r_tx_shift <= tx_data;
            r_hold     <= CPH;
            r_miso     <= CPH ? 1'b0 : tx_data[WIDTH-1];
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            // A partial word is dropped; a completed one is handled below.
            r_cnt  <= '0;
            r_miso <= 1'b0;
          end else if (w_done) begin
            r_cnt      <= '0;
            r_tx_shift <= tx_data;
            r_hold     <= 1'b1;
          end else begin
            if (w_sample) begin
              r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi};
              r_cnt      <= r_cnt + CNT_W'(1);
            end
            if (w_shift) begin
              if (r_hold) begin
                r_miso <= r_tx_shift[WIDTH-1];
                r_hold <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                r_miso     <= r_tx_shift[WIDTH-2];
              end
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Receive handshake: a completing word beats a simultaneous ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_done) begin
      r_rx_data  <= r_rx_shift;
      r_rx_valid <= 1'b1;
    end else if (rx_ack) begin
      r_rx_valid <= 1'b0;
    end
  end

`ifdef SPI_RX_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_overrun <= 1'b0;
    else if (w_done && r_rx_valid && !rx_ack)   r_overrun <= 1'b1;
    else if (rx_ack)                            r_overrun <= 1'b0;
  end

  assign rx_overrun = r_overrun;
`endif

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state == ACTIVE);

endmodule : receiver_spi
